// File: rtl/seq_nibble_adder.sv
// seq_nibble_adder: multi-cycle WIDTH-bit adder built around a single 4-bit adder slice.
// It accepts operands plus a carry-in on a valid/ready handshake, then adds one nibble
// per cycle (LSB first) and presents the result on a second valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand bundle valid      in_ready   block can accept operands
//   a, b       WIDTH-bit operands        cin        carry into nibble 0
//   out_valid  result valid              out_ready  downstream accepts result
//   sum        (a + b + cin) mod 2^WIDTH cout       carry out of the MSB nibble
//
// The file also holds the 4-bit `adder` slice so the design compiles on its own.

// adder: 4-bit combinational slice, {cout, sum} = in1 + in2 + cin.
module adder (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, in1} + {1'b0, in2} + {4'b0000, cin};
endmodule

module seq_nibble_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [3:0] slice_in1, slice_in2, slice_sum;
    logic       slice_cout;

    // Slice is fed from the latched operands only, so input changes during RUN are harmless.
    assign slice_in1 = a_q[4*idx_q +: 4];
    assign slice_in2 = b_q[4*idx_q +: 4];

    adder u_adder (
        .in1  (slice_in1),
        .in2  (slice_in2),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[4*idx_q +: 4] = slice_sum;
                carry_d             = slice_cout;
                if (idx_q == LastIdx) begin
                    cout_d  = slice_cout;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_seq_nibble_adder.sv
// Directed self-checking bench for seq_nibble_adder (WIDTH=16).
module tb_seq_nibble_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    int n_cmp;
    int n_fail;

    seq_nibble_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand bundle for one edge (accept edge E0); returns at E0+#1.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen, bounded to 20.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            n_cmp++;
            if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
                n_fail++;
                $display("FAIL reset_cycle%0d: got rdy=%b vld=%b cout=%b sum=%h, want 1 0 0 0000",
                         i, in_ready, out_valid, cout, sum);
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_after_reset: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_in_ready_run: got %b, want 0", in_ready);
        end
        wait_done(cyc);
        n_cmp++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL ripple_latency: got %0d cycles, want 4", cyc);
        end
        n_cmp++;
        if ({cout, sum} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL ripple_result: got cout=%b sum=%h, want 1 0000", cout, sum);
        end
        release_result();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL ripple_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_nominal();
        logic [15:0] va [2] = '{16'h1234, 16'hFFFF};
        logic [15:0] vb [2] = '{16'h4321, 16'hFFFF};
        logic        vc [2] = '{1'b1, 1'b1};
        logic [15:0] es [2] = '{16'h5556, 16'hFFFF};
        logic        ec [2] = '{1'b0, 1'b1};
        int cyc;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], vc[i]);
            wait_done(cyc);
            n_cmp++;
            if ({out_valid, cout, sum} !== {1'b1, ec[i], es[i]}) begin
                n_fail++;
                $display("FAIL nominal%0d: got vld=%b cout=%b sum=%h, want 1 %b %h",
                         i, out_valid, cout, sum, ec[i], es[i]);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(16'h7FFF, 16'h8000, 1'b0);
        wait_done(cyc);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'hFFFF}) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got vld=%b rdy=%b cout=%b sum=%h, want 1 0 0 ffff",
                         i, out_valid, in_ready, cout, sum);
            end
            @(posedge clk); #1;
        end
        release_result();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_operand_instability();
        int cyc;
        start_op(16'h0F0F, 16'h0101, 1'b0);
        // Scramble inputs while the block is busy.
        for (int i = 0; i < 3; i++) begin
            a = 16'hFFFF ^ 16'(i); b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        wait_done(cyc);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h1010}) begin
            n_fail++;
            $display("FAIL instability_result: got vld=%b cout=%b sum=%h, want 1 0 1010",
                     out_valid, cout, sum);
        end
        release_result();
    endtask

    task automatic test_reset_midop();
        int cyc;
        start_op(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_midop: got rdy=%b vld=%b cout=%b sum=%h, want 1 0 0 0000",
                     in_ready, out_valid, cout, sum);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop_no_result: got vld=%b, want 0", out_valid);
        end
        start_op(16'h0006, 16'h000D, 1'b0);
        wait_done(cyc);
        n_cmp++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h0013}) begin
            n_fail++;
            $display("FAIL reset_midop_fresh: got vld=%b cout=%b sum=%h, want 1 0 0013",
                     out_valid, cout, sum);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int hits;
        int cyc;
        first = -1; second = -1; hits = 0;
        a = 16'h00FF; b = 16'h0001; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 0; e < 13; e++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                hits++;
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (hits !== 2 || first !== 4 || second !== 10) begin
            n_fail++;
            $display("FAIL back_to_back_timing: got hits=%0d first=%0d second=%0d, want 2 4 10",
                     hits, first, second);
        end
        wait_done(cyc);
        n_cmp++;
        if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h0100}) begin
            n_fail++;
            $display("FAIL back_to_back_result: got vld=%b cout=%b sum=%h, want 1 0 0100",
                     out_valid, cout, sum);
        end
        release_result();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_ripple();
        test_nominal();
        test_backpressure();
        test_operand_instability();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
